echo_measure: RTL and testbench

Measures the HC-SR04 echo pulse width and converts it to distance in millimetres. It sits directly downstream of the trigger generator: the falling edge of `trig` arms one measurement, and the block then times the following echo high pulse in whole microseconds. It emits `dist_mm` with a one-cycle `dist_valid` strobe for the UART formatting stage. Runs on the system clock, not the 1 µs clock.

---
 rtl/hcsr04_pkg.sv | 26 ++
 rtl/sync_edge.sv | 32 +++
 rtl/echo_measure.sv | 130 +++++++++++++
 tb/tb_echo_measure.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hcsr04_pkg.sv
// Shared constants and types for the HC-SR04 ranging blocks.
// Holds the FSM encoding, the Q16 mm-per-us scale and the default time limits.
package hcsr04_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_CALC,
        ST_DRAIN
    } state_t;

    localparam int unsigned MM_PER_US_Q16    = 11239;
    localparam int unsigned MM_SHIFT         = 16;
    localparam int unsigned DEF_TIMEOUT_US   = 38000;
    localparam int unsigned DEF_WAIT_RISE_US = 2000;
    localparam int unsigned TRIG_PERIOD_US   = 60000;

    // (us * 11239) >> 16 ~= us * 0.17149 mm (half the speed of sound)
    function automatic logic [15:0] us_to_mm(input logic [15:0] us);
        logic [31:0] prod;
        prod = {16'd0, us} * 32'(MM_PER_US_Q16);
        return prod[31:16];
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with registered rise/fall detect.
// Pin-to-edge-pulse latency is three clock cycles.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
        end
    end

    assign level = s2;

endmodule

// File: rtl/echo_measure.sv
// Times the HC-SR04 echo high pulse in whole microseconds after a trig falling
// edge and converts it to millimetres, with timeouts for missing/endless echoes.
module echo_measure
    import hcsr04_pkg::*;
#(
    parameter int unsigned CLK_FREQ_MHZ = 50,
    parameter int unsigned WAIT_RISE_US = DEF_WAIT_RISE_US,
    parameter int unsigned TIMEOUT_US   = DEF_TIMEOUT_US
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        trig,
    input  logic        echo,
    output logic [15:0] dist_mm,
    output logic        dist_valid,
    output logic        timeout,
    output logic        busy
);

    localparam int unsigned PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ_MHZ - 1);
    localparam logic [15:0]   WAIT_LIM  = 16'(WAIT_RISE_US);
    localparam logic [15:0]   TO_LIM    = 16'(TIMEOUT_US);

    logic trig_level, trig_rise, trig_fall;
    logic echo_level, echo_rise, echo_fall;

    sync_edge u_sync_trig (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .din   (trig),
        .level (trig_level),
        .rise  (trig_rise),
        .fall  (trig_fall)
    );

    sync_edge u_sync_echo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .din   (echo),
        .level (echo_level),
        .rise  (echo_rise),
        .fall  (echo_fall)
    );

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [15:0]   echo_us, echo_us_nxt;
    logic          load_dist;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= ST_IDLE;
            presc   <= '0;
            echo_us <= '0;
            dist_mm <= '0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            echo_us <= echo_us_nxt;
            if (load_dist)
                dist_mm <= us_to_mm(echo_us_nxt);
        end
    end

    // The same us counter times both the wait for the rising edge and the pulse.
    // The fall-detect cycle still counts, so echo_us = floor(high cycles / f_MHz).
    always_comb begin
        state_nxt   = state;
        presc_nxt   = presc;
        echo_us_nxt = echo_us;
        timeout     = 1'b0;
        load_dist   = 1'b0;

        if (state == ST_WAIT_RISE || state == ST_MEASURE) begin
            if (presc == PRESC_MAX) begin
                presc_nxt   = '0;
                echo_us_nxt = echo_us + 16'd1;
            end else begin
                presc_nxt = presc + PW'(1);
            end
        end

        unique case (state)
            ST_IDLE: begin
                if (trig_fall) begin
                    state_nxt   = ST_WAIT_RISE;
                    presc_nxt   = '0;
                    echo_us_nxt = '0;
                end
            end
            ST_WAIT_RISE: begin
                if (echo_us == WAIT_LIM) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (echo_rise) begin
                    state_nxt   = ST_MEASURE;
                    presc_nxt   = '0;
                    echo_us_nxt = '0;
                end
            end
            ST_MEASURE: begin
                if (echo_us == TO_LIM) begin
                    timeout   = 1'b1;
                    state_nxt = ST_DRAIN;
                end else if (echo_fall) begin
                    load_dist = 1'b1;
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                if (!echo_level)
                    state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign dist_valid = (state == ST_CALC);
    assign busy       = (state != ST_IDLE);

    logic unused_ok;
    assign unused_ok = trig_level ^ trig_rise;

endmodule

// File: tb/tb_echo_measure.sv
// Scoreboard bench for echo_measure: stimulus pushes expected results, a monitor
// pops and compares on every dist_valid/timeout strobe.
module tb_echo_measure;

    localparam int unsigned CLK = 2;
    localparam int unsigned WR  = 600;
    localparam int unsigned TO  = 11000;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        trig = 1'b0;
    logic        echo = 1'b0;
    logic [15:0] dist_mm;
    logic        dist_valid;
    logic        timeout;
    logic        busy;

    echo_measure #(
        .CLK_FREQ_MHZ (CLK),
        .WAIT_RISE_US (WR),
        .TIMEOUT_US   (TO)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .trig       (trig),
        .echo       (echo),
        .dist_mm    (dist_mm),
        .dist_valid (dist_valid),
        .timeout    (timeout),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit          is_to;
        logic [15:0] mm;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every output strobe must match the oldest expected event.
    always @(negedge sys_clk) begin
        if (sys_rst_n && (dist_valid || timeout)) begin
            exp_t e;
            n_checks++;
            if (dist_valid && timeout) begin
                n_fail++;
                $display("FAIL strobe_both: dist_valid and timeout together");
            end else if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: valid=%0d timeout=%0d mm=%0d with nothing expected",
                         dist_valid, timeout, dist_mm);
            end else begin
                e = q.pop_front();
                if (timeout !== e.is_to || dist_mm !== e.mm) begin
                    n_fail++;
                    $display("FAIL scoreboard: got timeout=%0d mm=%0d expected timeout=%0d mm=%0d",
                             timeout, dist_mm, e.is_to, e.mm);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_us(input int n);
        wait_cyc(n * CLK);
    endtask

    task automatic push(input bit is_to, input logic [15:0] mm);
        exp_t e;
        e.is_to = is_to;
        e.mm    = mm;
        q.push_back(e);
    endtask

    // Counts negedges until the chosen strobe is seen; expiry counts as a failure.
    task automatic wait_flag(input bit want_to, input int limit, output int cnt);
        cnt = 0;
        forever begin
            @(negedge sys_clk);
            cnt++;
            if (want_to ? timeout : dist_valid) return;
            if (cnt >= limit) begin
                n_checks++;
                n_fail++;
                $display("FAIL wait_flag: no strobe within %0d cycles", limit);
                return;
            end
        end
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        wait_us(15);
        trig = 1'b0;
    endtask

    task automatic measure(input string name, input int width_us, input logic [15:0] exp);
        int c;
        pulse_trig();
        wait_cyc(5);
        check({name, "_busy_armed"}, busy, 1);
        wait_us(500);
        echo = 1'b1;
        push(1'b0, exp);
        wait_us(width_us);
        echo = 1'b0;
        wait_flag(1'b0, 20, c);
        check({name, "_valid_latency"}, c, 4);
        wait_cyc(2);
        check({name, "_busy_idle"}, busy, 0);
        check({name, "_mm_held"}, dist_mm, exp);
    endtask

    initial begin
        int c;

        // Reset held with echo high
        echo = 1'b1;
        wait_cyc(5);
        check("rst_dist_mm", dist_mm, 0);
        check("rst_dist_valid", dist_valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        sys_rst_n = 1'b1;
        wait_cyc(4);
        echo = 1'b0;
        wait_cyc(20);
        check("idle_no_trig_busy", busy, 0);

        measure("run1000", 1000, 16'd171);
        measure("run10000", 10000, 16'd1714);
        measure("run1000b", 1000, 16'd171);

        // Echo stuck high: timeout after TO us of echo, dist_mm retained
        pulse_trig();
        wait_us(100);
        echo = 1'b1;
        push(1'b1, 16'd171);
        wait_flag(1'b1, 30000, c);
        check("echo_to_latency", c, 4 + 2 * TO);
        wait_us(500);
        check("drain_busy", busy, 1);
        echo = 1'b0;
        wait_cyc(6);
        check("drain_exit_busy", busy, 0);
        check("echo_to_mm_kept", dist_mm, 171);

        // Missing echo: timeout WR us after trig falling edge
        push(1'b1, 16'd171);
        trig = 1'b1;
        wait_us(15);
        trig = 1'b0;
        wait_flag(1'b1, 3000, c);
        check("wait_rise_to_latency", c, 4 + 2 * WR);
        wait_cyc(2);
        check("wait_rise_to_busy", busy, 0);

        // Echo with no trig is ignored
        echo = 1'b1;
        wait_us(200);
        check("spurious_echo_busy", busy, 0);
        echo = 1'b0;
        wait_cyc(10);

        // Second trig during MEASURE is ignored
        pulse_trig();
        wait_us(100);
        echo = 1'b1;
        push(1'b0, 16'd171);
        wait_us(300);
        pulse_trig();
        wait_us(685);
        echo = 1'b0;
        wait_flag(1'b0, 20, c);
        check("retrig_valid_latency", c, 4);
        wait_cyc(10);
        check("retrig_not_queued", busy, 0);
        check("retrig_mm", dist_mm, 171);

        // Reset 300 us into echo high, released with echo still high
        pulse_trig();
        wait_us(100);
        echo = 1'b1;
        wait_us(300);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_dist_mm", dist_mm, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", dist_valid, 0);
        wait_cyc(3);
        sys_rst_n = 1'b1;
        wait_us(200);
        echo = 1'b0;
        wait_cyc(20);
        check("midrst_idle", busy, 0);
        measure("after_rst", 1000, 16'd171);

        // Sub-microsecond echo: zero distance but still strobed
        pulse_trig();
        wait_us(50);
        echo = 1'b1;
        push(1'b0, 16'd0);
        @(negedge sys_clk);
        echo = 1'b0;
        wait_flag(1'b0, 20, c);
        check("short_valid_latency", c, 4);
        wait_cyc(4);
        check("short_mm", dist_mm, 0);

        wait_cyc(10);
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
